imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Upstream program loader for the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them sequentially into instruction memory from word address 0. It verifies a length header and an XOR checksum, then releases the CPU by asserting `cpu_run`. The CPU's program counter is held while `cpu_run` is low.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: instruction memory word-address width.
- `MAX_WORDS`, 256: largest accepted program length in words; must be ≤ 2^ADDR_WIDTH.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a new load from any state.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a byte this cycle; a transfer occurs when `in_valid && in_ready`.
- `imem_we` out 1: instruction memory write strobe, asserted for one cycle per word.
- `imem_addr` out ADDR_WIDTH: word address of the write.
- `imem_wdata` out 32: word to write.
- `word_count` out ADDR_WIDTH+1: words written in the current load.
- `load_done` out 1: load completed with a good checksum.
- `load_err` out 1: load aborted because of a bad length or a checksum mismatch.
- `cpu_run` out 1: CPU release; equals `load_done`.

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
- Reset values: state IDLE; `in_ready`, `imem_we`, `load_done`, `load_err` and `cpu_run` are 0; `imem_addr`, `imem_wdata` and `word_count` are 0.
- Reset does not touch memory contents.
- `start` has priority over all other transitions, from every state. It moves the loader to LEN_HI and clears `word_count`, the byte counter, the checksum, `load_done`, `load_err` and `cpu_run`.
- `in_ready` is 1 in LEN_HI, LEN_LO, DATA and CHECK, and 0 in every other state. There is no backpressure inside DATA.
- LEN_HI: an accepted byte becomes N[15:8]; next state LEN_LO.
- LEN_LO: an accepted byte becomes N[7:0]. Next state:
  - N > MAX_WORDS: ERROR.
  - N == 0: CHECK.
  - otherwise: DATA.
- DATA:
  - Accepted bytes shift into a 32-bit assembler, first byte into bits [31:24].
  - Every accepted byte is XORed into the 8-bit checksum, which starts at 0x00.
  - A 2-bit byte counter wraps after the 4th byte. On that byte the assembled word is registered to `imem_wdata`, `imem_addr` = `word_count`[ADDR_WIDTH-1:0], and `imem_we` pulses for one cycle.
  - `word_count` increments at the same edge that `imem_we` rises.
  - After the 4th byte of word N, the next state is CHECK.
- CHECK: an accepted byte is compared with the running checksum. The length bytes are not part of the checksum.
  - Equal: DONE.
  - Unequal: ERROR.
- DONE: `load_done` = `cpu_run` = 1; the loader holds until `start` or `rst`.
- ERROR: `load_err` = 1 and `cpu_run` = 0; the loader holds until `start` or `rst`.
- Bytes presented while `in_ready` is 0 are ignored, and no state changes.
- A `start` mid-load abandons the partial word, and no write is issued for it. Words already written stay in memory.

## Timing
- One byte per cycle at most; a full-rate stream is never stalled.
- Write latency: `imem_we` is high in the cycle after the 4th byte of a word is accepted.
- The checksum byte may be accepted in the same cycle as the final `imem_we` pulse; this is legal.
- `load_done`, `load_err` and `cpu_run` change in the cycle after the deciding byte is accepted. That byte is LEN_LO for a bad length and the checksum byte otherwise.
- Minimum load time from `start` to `cpu_run` = 1 + 2 + 4N + 1 cycles with continuous `in_valid`.
- `start` and `in_valid` together in the same cycle: `start` wins, and the byte is not consumed.
- `rst` and `start` together: `rst` wins, and the loader ends in IDLE.

## Test plan
- **Two-word load.** Stimulus: `start`, then bytes 00 02, 12 34 56 78, 9A BC DE F0, checksum 0x00 (XOR of payload), all with continuous `in_valid`.
  - Required: writes of 0x12345678 at address 0 and 0x9ABCDEF0 at address 1.
  - Required: `word_count` = 2, and `load_done` = `cpu_run` = 1 at cycle 12 after `start`.
- **Bad checksum.** Stimulus: the same stream with checksum 0xFF.
  - Required: both writes occur, then `load_err` = 1 and `cpu_run` = 0.
- **Oversize length.** Stimulus: length 0x0101 with MAX_WORDS = 256.
  - Required: ERROR the cycle after the LEN_LO byte, no `imem_we`, and `in_ready` = 0 afterwards.
- **Zero length.** Stimulus: bytes 00 00 00.
  - Required: no writes, `load_done` = 1, `word_count` = 0.
- **Gapped stream and restart.** Stimulus: random `in_valid` gaps in the two-word load; then a `start` pulse after byte 5, followed by a full one-word load of 0xDEADBEEF with checksum 0x22.
  - Required: no write from the abandoned partial word.
  - Required: address 0 is written with 0xDEADBEEF, and `load_done` = 1.
- **Reset mid-load.** Stimulus: `rst` asserted during DATA.
  - Required: all outputs return to their reset values next cycle, state IDLE, and `in_ready` = 0 until `start`.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: length header, big-endian word assembly into
// instruction memory, XOR checksum verification and CPU release.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  load_done,
    output logic                  load_err,
    output logic                  cpu_run
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [ADDR_WIDTH:0] WC_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] WC_ZERO = {(ADDR_WIDTH+1){1'b0}};

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    function automatic logic accepts_bytes(input state_t s);
        logic r;
        case (s)
            S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

    state_t                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [23:0]           asm_q, asm_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [7:0]            csum_q, csum_d;
    logic                  in_ready_q, in_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
    logic                  cpu_run_q, cpu_run_d;

    logic                  accept_s;
    logic [15:0]           full_len_s;
    logic [ADDR_WIDTH:0]   word_count_inc_s;

    assign accept_s         = in_valid && in_ready_q;
    assign full_len_s       = {len_hi_q, in_data};
    assign word_count_inc_s = word_count_q + WC_ONE;

    // Next-state and next-output computation for the whole loader.
    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        len_d        = len_q;
        asm_d        = asm_q;
        byte_cnt_d   = byte_cnt_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        word_count_d = word_count_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;
        cpu_run_d    = cpu_run_q;

        if (start) begin
            // A restart drops any partial word; the byte on in_data is not consumed.
            state_d      = S_LEN_HI;
            word_count_d = WC_ZERO;
            byte_cnt_d   = 2'd0;
            csum_d       = 8'h00;
            asm_d        = 24'h000000;
            load_done_d  = 1'b0;
            load_err_d   = 1'b0;
            cpu_run_d    = 1'b0;
        end else if (accept_s) begin
            case (state_q)
                S_LEN_HI: begin
                    len_hi_d = in_data;
                    state_d  = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_d = full_len_s[ADDR_WIDTH:0];
                    if (32'(full_len_s) > 32'(MAX_WORDS)) begin
                        state_d    = S_ERROR;
                        load_err_d = 1'b1;
                    end else if (full_len_s == 16'h0000) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    csum_d     = csum_update(csum_q, in_data);
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_wdata_d = {asm_q, in_data};
                        imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
                        word_count_d = word_count_inc_s;
                        asm_d        = 24'h000000;
                        if (word_count_inc_s == len_q) begin
                            state_d = S_CHECK;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        asm_d = {asm_q[15:0], in_data};
                    end
                end
                S_CHECK: begin
                    if (in_data == csum_q) begin
                        state_d     = S_DONE;
                        load_done_d = 1'b1;
                        cpu_run_d   = 1'b1;
                    end else begin
                        state_d    = S_ERROR;
                        load_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        in_ready_d = accepts_bytes(state_d);
    end

    // State and registered outputs; reset leaves memory untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_hi_q     <= 8'h00;
            len_q        <= WC_ZERO;
            asm_q        <= 24'h000000;
            byte_cnt_q   <= 2'd0;
            csum_q       <= 8'h00;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= {ADDR_WIDTH{1'b0}};
            imem_wdata_q <= 32'h00000000;
            word_count_q <= WC_ZERO;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            cpu_run_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            asm_q        <= asm_d;
            byte_cnt_q   <= byte_cnt_d;
            csum_q       <= csum_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            word_count_q <= word_count_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            cpu_run_q    <= cpu_run_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign word_count = word_count_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign cpu_run    = cpu_run_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed and randomized loads
// compared against a stream-level model of the loader's rules.
module tb_imem_boot_loader;

    localparam int AW   = 8;
    localparam int MAXW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;
    logic          load_done;
    logic          load_err;
    logic          cpu_run;

    imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .load_done(load_done),
        .load_err(load_err), .cpu_run(cpu_run)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int run_cyc = -1;
    int err_cyc = -1;
    int wr_addr[$];
    logic [31:0] wr_data[$];
    int wr_cyc[$];
    int acc_cyc[$];
    logic [31:0] mem [0:255];

    // Edge monitor: cyc counts rising edges; writes and first flag cycles are logged.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (imem_we) begin
            wr_addr.push_back(int'(imem_addr));
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
            mem[imem_addr] = imem_wdata;
        end
        if (cpu_run && run_cyc < 0) run_cyc = cyc;
        if (load_err && err_cyc < 0) err_cyc = cyc;
    end

    // Stream-level model: length header, payload words, XOR checksum verdict.
    task automatic model(input logic [7:0] b[$], output logic [31:0] w[$],
                         output bit done, output bit err, output int dec);
        int n;
        logic [7:0] chk;
        w = {};
        done = 0;
        err = 0;
        n = int'({b[0], b[1]});
        if (n > MAXW) begin
            err = 1;
            dec = 1;
            return;
        end
        chk = 8'h00;
        for (int k = 0; k < n; k++) begin
            w.push_back({b[2+4*k], b[3+4*k], b[4+4*k], b[5+4*k]});
            for (int j = 0; j < 4; j++) chk = chk ^ b[2+4*k+j];
        end
        dec = 2 + 4 * n;
        if (b[dec] == chk) done = 1;
        else err = 1;
    endtask

    task automatic do_start(input bit with_byte);
        run_cyc = -1;
        err_cyc = -1;
        wr_addr = {};
        wr_data = {};
        wr_cyc = {};
        acc_cyc = {};
        start = 1'b1;
        in_valid = with_byte;
        in_data = 8'hAA;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic drive_stream(input logic [7:0] b[$], input int gap_pct);
        foreach (b[i]) begin
            while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data = b[i];
            @(negedge clk);
            acc_cyc.push_back(cyc);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_load(input string name, input logic [7:0] b[$], input bit continuous);
        logic [31:0] w[$];
        bit done, err;
        int dec, got_cyc;
        model(b, w, done, err, dec);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_data.size() != w.size()) begin
            errors++;
            $display("FAIL %s write_count got %0d exp %0d", name, wr_data.size(), w.size());
        end
        foreach (w[k]) begin
            if (k < wr_data.size()) begin
                checks++;
                if (wr_addr[k] != k || wr_data[k] !== w[k]) begin
                    errors++;
                    $display("FAIL %s write[%0d] got addr=%0d data=%h exp addr=%0d data=%h",
                             name, k, wr_addr[k], wr_data[k], k, w[k]);
                end
                if (continuous) begin
                    checks++;
                    if (wr_cyc[k] != start_cyc + 2 + 4 * (k + 1)) begin
                        errors++;
                        $display("FAIL %s write_latency[%0d] got %0d exp %0d", name, k,
                                 wr_cyc[k] - start_cyc, 2 + 4 * (k + 1));
                    end
                end
            end
        end
        checks++;
        if (word_count !== (AW+1)'(w.size())) begin
            errors++;
            $display("FAIL %s word_count got %0d exp %0d", name, word_count, w.size());
        end
        checks++;
        if (load_done !== done || cpu_run !== done || load_err !== err || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s flags got done=%b run=%b err=%b rdy=%b exp done=%b run=%b err=%b rdy=0",
                     name, load_done, cpu_run, load_err, in_ready, done, done, err);
        end
        got_cyc = done ? run_cyc : err_cyc;
        checks++;
        if (dec >= acc_cyc.size() || got_cyc != acc_cyc[dec]) begin
            errors++;
            $display("FAIL %s flag_cycle got %0d exp %0d", name, got_cyc,
                     (dec < acc_cyc.size()) ? acc_cyc[dec] : -1);
        end
        if (continuous && done) begin
            // Flag rises 3+4N edges after the start edge, i.e. in cycle 4+4N counting the start cycle as 0.
            checks++;
            if (run_cyc - start_cyc != 3 + 4 * w.size()) begin
                errors++;
                $display("FAIL %s run_latency got %0d exp %0d", name, run_cyc - start_cyc,
                         3 + 4 * w.size());
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (in_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'h0 ||
            word_count !== '0 || load_done !== 1'b0 || load_err !== 1'b0 || cpu_run !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs got rdy=%b we=%b addr=%h wd=%h wc=%0d done=%b err=%b run=%b exp all 0",
                     name, in_ready, imem_we, imem_addr, imem_wdata, word_count,
                     load_done, load_err, cpu_run);
        end
    endtask

    task automatic test_reset();
        logic [7:0] junk[$];
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        wr_data = {};
        junk = '{8'h00, 8'h01, 8'h11, 8'h22};
        drive_stream(junk, 0);
        @(negedge clk);
        check_outputs_zero("idle_ignores_bytes");
        checks++;
        if (wr_data.size() != 0) begin
            errors++;
            $display("FAIL idle_writes got %0d exp 0", wr_data.size());
        end
    endtask

    task automatic test_two_word();
        logic [7:0] s[$];
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
        do_start(1'b0);
        drive_stream(s, 0);
        check_load("two_word", s, 1'b1);
    endtask

    task automatic test_bad_checksum();
        logic [7:0] s[$];
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hFF};
        do_start(1'b0);
        drive_stream(s, 0);
        check_load("bad_checksum", s, 1'b1);
    endtask

    task automatic test_oversize();
        logic [7:0] s[$];
        s = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        do_start(1'b0);
        drive_stream(s, 0);
        check_load("oversize", s, 1'b0);
    endtask

    task automatic test_zero_length();
        logic [7:0] s[$];
        s = '{8'h00, 8'h00, 8'h00};
        do_start(1'b0);
        drive_stream(s, 0);
        check_load("zero_length", s, 1'b1);
    endtask

    task automatic test_gapped_restart();
        logic [7:0] s[$];
        logic [7:0] part[$];
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
        do_start(1'b0);
        drive_stream(s, 35);
        check_load("gapped_two_word", s, 1'b0);
        part = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56};
        do_start(1'b0);
        drive_stream(part, 35);
        // Restart with a simultaneous valid byte, which must not be consumed.
        do_start(1'b1);
        checks++;
        if (wr_data.size() != 0 || in_ready !== 1'b1 || word_count !== '0) begin
            errors++;
            $display("FAIL abandoned_word got writes=%0d rdy=%b wc=%0d exp writes=0 rdy=1 wc=0",
                     wr_data.size(), in_ready, word_count);
        end
        s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        drive_stream(s, 35);
        check_load("restart_one_word", s, 1'b0);
        checks++;
        if (mem[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL restart_mem0 got %h exp deadbeef", mem[0]);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] s[$];
        logic [7:0] junk[$];
        s = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        do_start(1'b0);
        drive_stream(s, 0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h06;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check_outputs_zero("reset_mid_load");
        wr_data = {};
        junk = '{8'h07, 8'h08, 8'h09};
        drive_stream(junk, 0);
        @(negedge clk);
        check_outputs_zero("after_reset_ignore");
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || wr_data.size() != 0) begin
            errors++;
            $display("FAIL rst_beats_start got rdy=%b writes=%0d exp rdy=0 writes=0",
                     in_ready, wr_data.size());
        end
    endtask

    task automatic test_random_loads();
        logic [7:0] s[$];
        logic [7:0] chk;
        int n;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(6, 0);
            s = {};
            s.push_back(8'h00);
            s.push_back(8'(n));
            chk = 8'h00;
            for (int j = 0; j < 4 * n; j++) begin
                s.push_back(8'($urandom_range(255, 0)));
                chk = chk ^ s[s.size()-1];
            end
            if ($urandom_range(1, 0) == 1) chk = chk ^ 8'($urandom_range(255, 1));
            s.push_back(chk);
            do_start(1'b0);
            drive_stream(s, 30);
            check_load($sformatf("random_%0d", it), s, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_bad_checksum();
        test_oversize();
        test_zero_length();
        test_gapped_restart();
        test_reset_mid_load();
        test_random_loads();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
